// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz sequencer: default sizes and controller states.
package collatz_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 8;

  // Controller states; plain constants so older tools can share this package.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/collatz_seq_ctrl_if.sv
// Pin-side bundle of the Collatz sequencer: serial load, start, status and nibble readout.
interface collatz_seq_ctrl_if
  import collatz_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             load_en;
  logic             load_bit;
  logic             start;
  logic             busy;
  logic             done;
  logic             zero_err;
  logic             ovf;
  logic             cnt_sat;
  logic [CNT_W-1:0] steps;
  logic [1:0]       nib_sel;
  logic [3:0]       out_nib;

  // Driver side (pins / bench).
  modport master (
    output load_en, load_bit, start, nib_sel,
    input  busy, done, zero_err, ovf, cnt_sat, steps, out_nib
  );

  // Sequencer side.
  modport slave (
    input  load_en, load_bit, start, nib_sel,
    output busy, done, zero_err, ovf, cnt_sat, steps, out_nib
  );

endinterface

// File: rtl/collatz_step_unit.sv
// Combinational Collatz step: x/2 for even x, 3x+1 for odd x, with overflow detect.
module collatz_step_unit
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] next_x,
  output logic             odd,
  output logic             ovf
);

  // 3x+1 needs two extra bits: 3*(2^W-1)+1 < 2^(W+2).
  logic [WIDTH+1:0] triple;

  // Compute both candidates and pick by parity.
  always_comb begin
    triple = {2'b00, x} + {1'b0, x, 1'b0} + (WIDTH+2)'(1);
    odd    = x[0];
    // Raw overflow of 3x+1; the controller only heeds it for odd x.
    ovf    = |triple[WIDTH+1:WIDTH];
    next_x = odd ? triple[WIDTH-1:0] : {1'b0, x[WIDTH-1:1]};
  end

endmodule

// File: rtl/collatz_seq_ctrl.sv
// Collatz sequencer: serial start-value load, run FSM, step counter and nibble readout.
module collatz_seq_ctrl
  import collatz_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  collatz_seq_ctrl_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             zero_err_q, zero_err_d;
  logic             ovf_q, ovf_d;
  logic             cnt_sat_q, cnt_sat_d;

  logic [WIDTH-1:0] step_next;
  logic             step_odd;
  logic             step_ovf;
  logic             can_load;
  logic             accept;
  logic [15:0]      steps_ext;

  collatz_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .x      (x_q),
    .next_x (step_next),
    .odd    (step_odd),
    .ovf    (step_ovf)
  );

  // Load and start are only honoured outside a run; load wins over start.
  always_comb begin
    can_load = (state_q == IDLE) || (state_q == DONE);
    accept   = can_load && bus.start && !bus.load_en;
  end

  // Next-state logic for the FSM, shadow shifter, running value, counter and flags.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    x_d        = x_q;
    steps_d    = steps_q;
    zero_err_d = zero_err_q;
    ovf_d      = ovf_q;
    cnt_sat_d  = cnt_sat_q;

    if (can_load && bus.load_en) begin
      shadow_d = {shadow_q[WIDTH-2:0], bus.load_bit};
    end

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d    = RUN;
          x_d        = shadow_q;
          steps_d    = '0;
          zero_err_d = 1'b0;
          ovf_d      = 1'b0;
          cnt_sat_d  = 1'b0;
        end
      end
      RUN: begin
        if (x_q == '0) begin
          state_d    = DONE;
          zero_err_d = 1'b1;
        end else if (x_q == WIDTH'(1)) begin
          state_d = DONE;
        end else if (&steps_q) begin
          state_d   = DONE;
          cnt_sat_d = 1'b1;
        end else if (step_odd && step_ovf) begin
          // x and steps keep the last representable value.
          state_d = DONE;
          ovf_d   = 1'b1;
        end else begin
          x_d     = step_next;
          steps_d = steps_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      x_q        <= '0;
      steps_q    <= '0;
      zero_err_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_sat_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      x_q        <= x_d;
      steps_q    <= steps_d;
      zero_err_q <= zero_err_d;
      ovf_q      <= ovf_d;
      cnt_sat_q  <= cnt_sat_d;
    end
  end

  // Status outputs and nibble readout; nibbles past CNT_W read as zero.
  always_comb begin
    steps_ext    = 16'(steps_q);
    bus.busy     = (state_q == RUN);
    bus.done     = (state_q == DONE);
    bus.zero_err = zero_err_q;
    bus.ovf      = ovf_q;
    bus.cnt_sat  = cnt_sat_q;
    bus.steps    = steps_q;
    bus.out_nib  = steps_ext[{bus.nib_sel, 2'b00} +: 4];
  end

endmodule

// File: tb/tb_collatz_seq_ctrl.sv
// Bench for collatz_seq_ctrl: three configurations driven in lockstep, scoreboard of
// expected run results computed by a behavioural Collatz model.
module tb_collatz_seq_ctrl;

  localparam int WID [3] = '{8, 16, 16};
  localparam int CW  [3] = '{8, 8, 4};

  typedef struct {
    int   steps;
    logic z;
    logic o;
    logic s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en, load_bit, start;
  logic [1:0] nib_sel;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   busy_cnt[3];
  bit   tmo;

  always #5 clk = ~clk;

  collatz_seq_ctrl_if #(.CNT_W(8)) bus0 ();
  collatz_seq_ctrl_if #(.CNT_W(8)) bus1 ();
  collatz_seq_ctrl_if #(.CNT_W(4)) bus2 ();

  assign bus0.load_en = load_en;  assign bus0.load_bit = load_bit;
  assign bus0.start   = start;    assign bus0.nib_sel  = nib_sel;
  assign bus1.load_en = load_en;  assign bus1.load_bit = load_bit;
  assign bus1.start   = start;    assign bus1.nib_sel  = nib_sel;
  assign bus2.load_en = load_en;  assign bus2.load_bit = load_bit;
  assign bus2.start   = start;    assign bus2.nib_sel  = nib_sel;

  collatz_seq_ctrl #(.WIDTH(8),  .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  collatz_seq_ctrl #(.WIDTH(16), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  collatz_seq_ctrl #(.WIDTH(16), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic [2:0] busy_v, done_v, zerr_v, ovf_v, sat_v;
  logic [7:0] steps_v [3];
  logic [3:0] nib_v [3];

  assign busy_v = {bus2.busy, bus1.busy, bus0.busy};
  assign done_v = {bus2.done, bus1.done, bus0.done};
  assign zerr_v = {bus2.zero_err, bus1.zero_err, bus0.zero_err};
  assign ovf_v  = {bus2.ovf, bus1.ovf, bus0.ovf};
  assign sat_v  = {bus2.cnt_sat, bus1.cnt_sat, bus0.cnt_sat};
  assign steps_v[0] = bus0.steps;
  assign steps_v[1] = bus1.steps;
  assign steps_v[2] = {4'b0000, bus2.steps};
  assign nib_v[0] = bus0.out_nib;
  assign nib_v[1] = bus1.out_nib;
  assign nib_v[2] = bus2.out_nib;

  // Behavioural reference: walk the sequence with integers and the stated abort order.
  function automatic exp_t model(input int w, input int cw, input int n);
    exp_t r;
    int   x;
    x = n;
    r = '{steps: 0, z: 1'b0, o: 1'b0, s: 1'b0};
    for (int k = 0; k < 100000; k++) begin
      if (x == 0) begin r.z = 1'b1; break; end
      if (x == 1) break;
      if (r.steps == (1 << cw) - 1) begin r.s = 1'b1; break; end
      if ((x % 2) == 1 && (3 * x + 1) > (1 << w) - 1) begin r.o = 1'b1; break; end
      x = ((x % 2) == 1) ? 3 * x + 1 : x / 2;
      r.steps++;
    end
    return r;
  endfunction

  task automatic push_expected(input int v);
    for (int i = 0; i < 3; i++) sbq.push_back(model(WID[i], CW[i], v));
  endtask

  task automatic do_load(input int v);
    for (int b = 15; b >= 0; b--) begin
      @(negedge clk);
      load_en  = 1'b1;
      load_bit = v[b];
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles per instance until every instance has left RUN (bounded).
  task automatic wait_done();
    bit fin[3];
    fin      = '{1'b0, 1'b0, 1'b0};
    busy_cnt = '{0, 0, 0};
    tmo      = 1'b1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!fin[i]) begin
          if (busy_v[i]) busy_cnt[i]++;
          else fin[i] = 1'b1;
        end
      end
      if (fin[0] && fin[1] && fin[2]) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load_en = 1'b0; load_bit = 1'b0; start = 1'b0; nib_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_v[i], done_v[i], zerr_v[i], ovf_v[i], sat_v[i]} !== 5'b0 ||
          steps_v[i] !== 8'd0 || nib_v[i] !== 4'd0) begin
        errors++;
        $display("FAIL reset inst=%0d flags=%b steps=%0d nib=%0d required all 0", i,
                 {busy_v[i], done_v[i], zerr_v[i], ovf_v[i], sat_v[i]}, steps_v[i], nib_v[i]);
      end
    end
  endtask

  task automatic test_runs();
    int   vals[7] = '{1, 6, 27, 0, 7, 3, 255};
    exp_t e;
    foreach (vals[k]) begin
      do_load(vals[k]);
      push_expected(vals[k]);
      do_start();
      wait_done();
      checks++;
      if (tmo) begin
        errors++;
        $display("FAIL runs_timeout v=%0d busy=%b required 000", vals[k], busy_v);
      end
      for (int i = 0; i < 3; i++) begin
        e = sbq.pop_front();
        checks++;
        if (steps_v[i] !== 8'(e.steps) || done_v[i] !== 1'b1 ||
            {zerr_v[i], ovf_v[i], sat_v[i]} !== {e.z, e.o, e.s}) begin
          errors++;
          $display("FAIL runs v=%0d inst=%0d steps=%0d done=%b zos=%b required %0d 1 %b",
                   vals[k], i, steps_v[i], done_v[i], {zerr_v[i], ovf_v[i], sat_v[i]},
                   e.steps, {e.z, e.o, e.s});
        end
        checks++;
        if (busy_cnt[i] !== e.steps + 1) begin
          errors++;
          $display("FAIL busy_len v=%0d inst=%0d got %0d required %0d",
                   vals[k], i, busy_cnt[i], e.steps + 1);
        end
      end
    end
  endtask

  task automatic test_nibble();
    exp_t e[3];
    do_load(27);
    push_expected(27);
    do_start();
    wait_done();
    for (int i = 0; i < 3; i++) e[i] = sbq.pop_front();
    for (int sel = 0; sel < 4; sel++) begin
      nib_sel = 2'(sel);
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (nib_v[i] !== 4'((e[i].steps >> (4 * sel)) & 15)) begin
          errors++;
          $display("FAIL nibble inst=%0d sel=%0d got %h required %h", i, sel, nib_v[i],
                   4'((e[i].steps >> (4 * sel)) & 15));
        end
      end
    end
    nib_sel = 2'd0;
  endtask

  task automatic test_ignored();
    exp_t e;
    do_load(27);
    push_expected(27);
    do_start();
    // Start and load pulses while busy must not disturb the run or the shadow.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; load_en = 1'b1; load_bit = 1'b1;
    @(negedge clk); load_en = 1'b0;
    wait_done();
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      checks++;
      if (steps_v[i] !== 8'(e.steps) || {zerr_v[i], ovf_v[i], sat_v[i]} !== {e.z, e.o, e.s}) begin
        errors++;
        $display("FAIL busy_start inst=%0d steps=%0d zos=%b required %0d %b", i, steps_v[i],
                 {zerr_v[i], ovf_v[i], sat_v[i]}, e.steps, {e.z, e.o, e.s});
      end
    end
    // Start together with load_en: the bit shifts in, no run starts.
    start = 1'b1; load_en = 1'b1; load_bit = 1'b0;
    @(negedge clk);
    start = 1'b0; load_en = 1'b0;
    checks++;
    if (busy_v !== 3'b000 || done_v !== 3'b111) begin
      errors++;
      $display("FAIL load_prio busy=%b done=%b required 000 111", busy_v, done_v);
    end
    push_expected(54);
    do_start();
    wait_done();
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      checks++;
      if (steps_v[i] !== 8'(e.steps) || {zerr_v[i], ovf_v[i], sat_v[i]} !== {e.z, e.o, e.s}) begin
        errors++;
        $display("FAIL shadow54 inst=%0d steps=%0d zos=%b required %0d %b", i, steps_v[i],
                 {zerr_v[i], ovf_v[i], sat_v[i]}, e.steps, {e.z, e.o, e.s});
      end
    end
  endtask

  task automatic test_midrun_reset();
    exp_t e;
    do_load(27);
    do_start();
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy_v[i], done_v[i], zerr_v[i], ovf_v[i], sat_v[i]} !== 5'b0 ||
          steps_v[i] !== 8'd0) begin
        errors++;
        $display("FAIL midrun_rst inst=%0d flags=%b steps=%0d required 0 0", i,
                 {busy_v[i], done_v[i], zerr_v[i], ovf_v[i], sat_v[i]}, steps_v[i]);
      end
    end
    #1 rst = 1'b0;
    // Shadow was cleared, so a bare start runs from 0.
    push_expected(0);
    do_start();
    wait_done();
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      checks++;
      if (zerr_v[i] !== e.z || steps_v[i] !== 8'(e.steps) || busy_cnt[i] !== 1) begin
        errors++;
        $display("FAIL zero_after_rst inst=%0d zerr=%b steps=%0d busy=%0d required %b %0d 1",
                 i, zerr_v[i], steps_v[i], busy_cnt[i], e.z, e.steps);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_load(6);
    push_expected(6);
    do_start();
    wait_done();
    for (int i = 0; i < 3; i++) void'(sbq.pop_front());
    // Restart in the first DONE cycle.
    start = 1'b1;
    push_expected(6);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy_v !== 3'b111 || done_v !== 3'b000) begin
      errors++;
      $display("FAIL b2b_accept busy=%b done=%b required 111 000", busy_v, done_v);
    end
    wait_done();
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      checks++;
      if (steps_v[i] !== 8'(e.steps) || busy_cnt[i] !== e.steps + 1 || tmo) begin
        errors++;
        $display("FAIL b2b inst=%0d steps=%0d busy=%0d required %0d %0d", i, steps_v[i],
                 busy_cnt[i], e.steps, e.steps + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_nibble();
    test_ignored();
    test_midrun_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
